dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Arbitrates the single data RAM (10-bit word address [11:2], 32-bit data, 1-cycle synchronous read) between the CPU load/store port and the UART monitor port.
- Sits between the CPU memory stage, the monitor's d_ram_* signals and the data RAM. It replaces the static d_read_sel mux.
- Gives the CPU priority while it runs and prevents monitor starvation. Offers a monitor lock so that dump, trash and fill sequences get exclusive ownership.

Parameters:
ADR_W, 10, word address width (byte address bits [11:2])
DATA_W, 32, data width
MON_MAX_WAIT, 8, consecutive denied monitor cycles before the monitor is forced to win (range 1..15)
CNT_W, 4, starvation counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_running  in  1  CPU executing (cpu_start issued, not quit)
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = write, 0 = read
cpu_adr  in  ADR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
mon_req  in  1  monitor access request
mon_we  in  1  1 = write, 0 = read
mon_adr  in  ADR_W  monitor word address
mon_wdata  in  DATA_W  monitor write data
mon_gnt  out  1  monitor access accepted this cycle (combinational)
mon_rvalid  out  1  monitor read data valid
mon_rdata  out  DATA_W  monitor read data
mon_lock  in  1  monitor requests exclusive ownership (level)
lock_ack  out  1  exclusive ownership held (registered)
ram_radr  out  ADR_W  RAM read address
ram_wadr  out  ADR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
ram_wen  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_radr

Behaviour:
- Clock and reset: one clock, clk. rst_n is an asynchronous, active-low reset.
- Reset values: state = S_NORM, lock_ack = 0, starvation counter = 0, cpu_rvalid = 0, mon_rvalid = 0, read-owner tag = none. All registered outputs read 0.
- Access rate: at most one RAM access per cycle. Every access is single-cycle. A requester holds req/we/adr/wdata stable until it sees gnt.
- State machine:
  - S_NORM -> S_LOCK on the clock edge where mon_lock = 1.
  - S_LOCK -> S_NORM on the clock edge where mon_lock = 0.
  - lock_ack = (state == S_LOCK). It rises one cycle after mon_lock rises.
- Grant in S_NORM (combinational):
  - force = (cnt >= MON_MAX_WAIT).
  - If cpu_running and force is 0: CPU wins whenever cpu_req is 1.
  - If cpu_running and force is 1: monitor wins when mon_req is 1.
  - If cpu_running is 0: monitor wins whenever mon_req is 1.
  - Otherwise the single requester wins.
  - cpu_gnt and mon_gnt are never both 1.
- Grant in S_LOCK: cpu_gnt = 0 always. mon_gnt = mon_req.
- Starvation counter:
  - Increments, saturating at MON_MAX_WAIT, on each cycle with mon_req = 1 and mon_gnt = 0.
  - Clears on mon_gnt, or when mon_req = 0.
  - Holds at 0 in S_LOCK.
- RAM drive:
  - ram_wen = winner_we & grant.
  - ram_wadr = ram_radr = winner address. With no grant, both show cpu_adr.
  - ram_wdata = winner wdata.
- Read return:
  - A granted read registers owner tag (CPU or MON).
  - Next cycle, the matching *_rvalid = 1 for exactly one cycle, and *_rdata = ram_rdata.
  - The non-owner's rdata holds its last captured value.
  - Reads are pipelined: back-to-back grants give back-to-back rvalid, each routed by its own tag.
- Write return: a granted write produces no rvalid.
- Lock entry or exit with a read in flight: the in-flight read completes normally to its tagged owner.
- Lock while CPU stalled: CPU requests during S_LOCK stay pending (cpu_gnt = 0). They win on the first S_NORM cycle, subject to the priority rules.
- cpu_running falls mid-contention: priority switches to the monitor in the same cycle (combinational).
- Reset mid-operation: state returns to S_NORM, the counter clears, the in-flight read is dropped (no rvalid) and lock_ack goes to 0.

Decomposition:
- A shared package holds:
  - state encoding S_NORM = 1'b0, S_LOCK = 1'b1;
  - owner tag encoding TAG_NONE = 2'd0, TAG_CPU = 2'd1, TAG_MON = 2'd2;
  - default ADR_W and DATA_W.
- One sub-module, dram_arb_rdret: owner-tag register, rvalid generation and the per-port rdata capture registers.
- Grant logic, starvation counter and FSM stay in the top.

Test Plan:
- cpu_running = 0; mon read adr 0x010 with RAM word 0xDEADBEEF -> mon_gnt = 1 same cycle; next cycle mon_rvalid = 1, mon_rdata = 0xDEADBEEF; cpu_rvalid stays 0.
- cpu_running = 1; cpu_req and mon_req held high for 20 cycles -> CPU granted cycles 0-7, monitor forced at cycle 8 (MON_MAX_WAIT = 8), CPU at 9-16, monitor at 17; never both granted.
- Alternating granted reads, CPU adr 0x001 (data 0x11111111) then mon adr 0x002 (data 0x22222222) in consecutive cycles -> cpu_rvalid at t+1 with 0x11111111, mon_rvalid at t+2 with 0x22222222.
- Lock:
  - Stimulus: mon_lock = 1 at t; cpu_req held; at t+2 mon write adr 0x3FF, data 0xA5A5A5A5; mon_lock = 0 at t+4.
  - Response: lock_ack = 1 at t+1 through t+4; cpu_gnt = 0 for t+1..t+4; ram_wen = 1 with ram_wadr = 0x3FF at t+2; cpu_gnt = 1 at t+5.
- Reset asserted the cycle after a granted CPU read -> no cpu_rvalid; all outputs 0; state S_NORM after release.
- CPU write adr 0x004, data 0x12345678 with mon idle -> ram_wen = 1, ram_wadr = 0x004, ram_wdata = 0x12345678, no rvalid.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - shared encodings and default widths for the data RAM arbiter
package dram_arbiter_pkg;

  localparam int DEF_ADR_W  = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    S_NORM = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_MON  = 2'd2
  } tag_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// rtl/dram_arbiter_if.sv - CPU, monitor and RAM signal bundle around the arbiter
interface dram_arbiter_if
  import dram_arbiter_pkg::*;
#(
  parameter int ADR_W  = DEF_ADR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cpu_running;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADR_W-1:0]  cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mon_req;
  logic              mon_we;
  logic [ADR_W-1:0]  mon_adr;
  logic [DATA_W-1:0] mon_wdata;
  logic              mon_gnt;
  logic              mon_rvalid;
  logic [DATA_W-1:0] mon_rdata;
  logic              mon_lock;
  logic              lock_ack;

  logic [ADR_W-1:0]  ram_radr;
  logic [ADR_W-1:0]  ram_wadr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_running, cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mon_req, mon_we, mon_adr, mon_wdata, mon_lock,
    output mon_gnt, mon_rvalid, mon_rdata, lock_ack,
    output ram_radr, ram_wadr, ram_wdata, ram_wen,
    input  ram_rdata
  );

  modport master (
    output cpu_running, cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output mon_req, mon_we, mon_adr, mon_wdata, mon_lock,
    input  mon_gnt, mon_rvalid, mon_rdata, lock_ack,
    input  ram_radr, ram_wadr, ram_wdata, ram_wen,
    output ram_rdata
  );

endinterface

// File: rtl/dram_arb_rdret.sv
// rtl/dram_arb_rdret.sv - routes 1-cycle RAM read data back to the port that issued the read
module dram_arb_rdret
  import dram_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_i,
  input  logic              mon_rd_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              mon_rvalid_o,
  output logic [DATA_W-1:0] mon_rdata_o
);

  tag_t              tag_q, tag_d;
  logic [DATA_W-1:0] cpu_rdata_q, mon_rdata_q;

  always_comb begin
    tag_d = TAG_NONE;
    if (mon_rd_i)      tag_d = TAG_MON;
    else if (cpu_rd_i) tag_d = TAG_CPU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= TAG_NONE;
      cpu_rdata_q <= '0;
      mon_rdata_q <= '0;
    end else begin
      tag_q <= tag_d;
      if (tag_q == TAG_CPU) cpu_rdata_q <= ram_rdata_i;
      if (tag_q == TAG_MON) mon_rdata_q <= ram_rdata_i;
    end
  end

  // The owner sees live RAM data on its valid cycle; the other port keeps its last capture.
  assign cpu_rvalid_o = (tag_q == TAG_CPU);
  assign mon_rvalid_o = (tag_q == TAG_MON);
  assign cpu_rdata_o  = cpu_rvalid_o ? ram_rdata_i : cpu_rdata_q;
  assign mon_rdata_o  = mon_rvalid_o ? ram_rdata_i : mon_rdata_q;

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - CPU/monitor data RAM arbiter with starvation guard and monitor lock
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADR_W        = DEF_ADR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MON_MAX_WAIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dram_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MON_MAX_WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_gnt, mon_gnt, force_mon;
  logic [ADR_W-1:0]  win_adr;
  logic [DATA_W-1:0] win_wdata;

  assign force_mon = (cnt_q >= MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NORM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = bus.mon_lock ? S_LOCK : S_NORM;
    cpu_gnt = 1'b0;
    mon_gnt = 1'b0;
    cnt_d   = '0;
    if (state_q == S_LOCK) begin
      mon_gnt = bus.mon_req;
    end else begin
      // CPU keeps priority only while it runs and the monitor has not waited too long.
      if (bus.cpu_running && !force_mon) begin
        cpu_gnt = bus.cpu_req;
        mon_gnt = bus.mon_req & ~bus.cpu_req;
      end else begin
        mon_gnt = bus.mon_req;
        cpu_gnt = bus.cpu_req & ~bus.mon_req;
      end
      if (bus.mon_req && !mon_gnt)
        cnt_d = force_mon ? MAX_CNT : cnt_q + 1'b1;
    end
  end

  assign win_adr   = mon_gnt ? bus.mon_adr   : bus.cpu_adr;
  assign win_wdata = mon_gnt ? bus.mon_wdata : bus.cpu_wdata;

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.mon_gnt   = mon_gnt;
  assign bus.lock_ack  = (state_q == S_LOCK);
  assign bus.ram_radr  = win_adr;
  assign bus.ram_wadr  = win_adr;
  assign bus.ram_wdata = win_wdata;
  assign bus.ram_wen   = (mon_gnt & bus.mon_we) | (cpu_gnt & bus.cpu_we);

  dram_arb_rdret #(
    .DATA_W (DATA_W)
  ) u_rdret (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_rd_i     (cpu_gnt & ~bus.cpu_we),
    .mon_rd_i     (mon_gnt & ~bus.mon_we),
    .ram_rdata_i  (bus.ram_rdata),
    .cpu_rvalid_o (bus.cpu_rvalid),
    .cpu_rdata_o  (bus.cpu_rdata),
    .mon_rvalid_o (bus.mon_rvalid),
    .mon_rdata_o  (bus.mon_rdata)
  );

endmodule
